ahb_apb_bridge: RTL and testbench
=================================

AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 SHALL have parameter PADDR_W, default 16, meaning APB address width; PADDR = latched HADDR[PADDR_W-1:0].
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 HCLK  in  1  clock; all logic on its rising edge.
REQ-004 HRESETn  in  1  asynchronous active-low reset.
REQ-005 HSEL  in  1  slave select, already decoded and registered upstream.
REQ-006 HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-007 HADDR  in  32  address.
REQ-008 HWRITE  in  1  1 = write.
REQ-009 HSIZE  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 HBURST  in  3  accepted and ignored; every beat is handled as a single transfer.
REQ-011 HWDATA  in  32  write data, valid in the data phase.
REQ-012 HREADYIN  in  1  bus-level HREADY, qualifies the address phase.
REQ-013 HREADY  out  1  data-phase completion.
REQ-014 HRESP  out  1  0 = OKAY, 1 = ERROR.
REQ-015 HRDATA  out  32  read data.
REQ-016 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-017 PADDR  out  PADDR_W  APB address.
REQ-018 PWDATA  out  32  APB write data.
REQ-019 PSTRB  out  4  APB byte strobes.
REQ-020 PRDATA  in  32, PREADY  in  1, PSLVERR  in  1  APB completer response.

Function
REQ-021 Accept a transfer when HSEL=1 and HTRANS[1]=1 and HREADYIN=1 and the state is IDLE or DONE; latch HADDR, HWRITE and HSIZE.
REQ-022 HTRANS IDLE/BUSY, or HSEL=0, SHALL start no transfer.
REQ-023 FSM states: IDLE, WCAP, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-024 On accept: a legal write goes to WCAP, a legal read goes to SETUP, HSIZE=11 goes to ERR1 with no APB access.
REQ-025 WCAP: HREADY=0; capture HWDATA into PWDATA; then go to SETUP.
REQ-026 SETUP: PSEL=1, PENABLE=0, HREADY=0; then go to ACCESS.
REQ-027 ACCESS: PSEL=1, PENABLE=1, HREADY=0.
REQ-028 ACCESS exits: PREADY=0 holds in ACCESS with all P-signals stable; PREADY=1 and PSLVERR=0 goes to DONE and captures PRDATA on reads; PREADY=1 and PSLVERR=1 goes to ERR1.
REQ-029 DONE: HREADY=1, HRESP=0, HRDATA = captured value; then go to IDLE unless a new transfer is accepted in the same cycle.
REQ-030 ERR1: HREADY=0, HRESP=1.
REQ-031 ERR2: HREADY=1, HRESP=1; then go to IDLE.
REQ-032 Transfers accepted in ERR1 or ERR2 SHALL be ignored.
REQ-033 PADDR, PWRITE, PSTRB and PWDATA SHALL be stable from SETUP through the end of ACCESS.
REQ-034 PSTRB on writes: byte = 4'b0001<<HADDR[1:0]; half = 4'b0011<<(2*HADDR[1]); word = 4'b1111.
REQ-035 PSTRB SHALL be 0 on reads.
REQ-036 Latency with zero APB wait states: a read completes with HREADY=1 in cycle N+3 and a write in cycle N+4 (N = address-phase cycle); each PREADY=0 cycle adds one cycle.
REQ-037 IDLE: HREADY=1, HRESP=0, PSEL=0, PENABLE=0.
REQ-038 Back-to-back: an accept in DONE goes directly to WCAP or SETUP with no IDLE cycle.

Reset
REQ-039 HRESETn=0 SHALL immediately force state IDLE and HREADY=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, independent of HCLK.
REQ-040 An assertion of HRESETn mid-ACCESS SHALL abort the transfer with no completion reported.
REQ-041 The first accept is possible on the first rising edge after HRESETn deasserts.

Verification
REQ-042 Word read at HADDR=0x0000_1234, PRDATA=0xDEAD_BEEF, PREADY=1 -> PADDR=0x1234, SETUP at N+1, ACCESS at N+2, HREADY=1 and HRDATA=0xDEAD_BEEF at N+3.
REQ-043 Byte write at HADDR=0x...03, HWDATA=0xAABBCCDD, 2 PREADY wait cycles -> PSTRB=4'b1000, PWDATA=0xAABBCCDD, PWRITE=1, HREADY=1 at N+6.
REQ-044 Read with PSLVERR=1 -> ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), then IDLE.
REQ-045 HSIZE=11 write -> PSEL stays 0, two-cycle ERROR response.
REQ-046 Back-to-back read then write, second NONSEQ presented in DONE -> WCAP follows DONE directly; no IDLE cycle.
REQ-047 HRESETn pulsed low during ACCESS with PREADY=0 -> PSEL=0 and HREADY=1 asynchronously; next transfer completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB bridge.
// Every AHB beat is turned into one APB transfer, handled as a single transfer
// regardless of burst type. Writes spend one extra cycle (WCAP) capturing
// HWDATA from the AHB data phase before the APB setup phase. An APB slave
// error, or an illegal HSIZE, produces the two-cycle AHB ERROR response.
module ahb_apb_bridge #(
  parameter int PADDR_W = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [1:0]         HTRANS,
  input  logic [31:0]        HADDR,
  input  logic               HWRITE,
  input  logic [1:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [31:0]        HWDATA,
  input  logic               HREADYIN,
  output logic               HREADY,
  output logic               HRESP,
  output logic [31:0]        HRDATA,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [PADDR_W-1:0] PADDR,
  output logic [31:0]        PWDATA,
  output logic [3:0]         PSTRB,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WCAP   = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic               r_pwrite;
  logic [PADDR_W-1:0] r_paddr;
  logic [31:0]        r_pwdata;
  logic [3:0]         r_pstrb;
  logic [31:0]        r_hrdata;

  logic w_accept;
  logic w_illegal_size;
  logic w_legal_accept;
  logic w_apb_done;

  // HBURST is deliberately ignored, HTRANS[0] (SEQ vs NONSEQ) makes no
  // difference here, and only the low PADDR_W address bits reach APB.
  logic w_unused_bits;
  assign w_unused_bits = ^{HBURST, HTRANS[0], HADDR};

  // Byte-lane strobes for a write of the given size at the given address.
  function automatic logic [3:0] f_write_strb(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'b00:   strb = 4'b0001 << addr_lo;
      2'b01:   strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // A new AHB transfer is only taken while the bridge is free to start one;
  // beats presented during ERR1/ERR2 fall outside this and are dropped.
  assign w_accept       = HSEL && HTRANS[1] && HREADYIN &&
                          ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_illegal_size = (HSIZE == 2'b11);
  assign w_legal_accept = w_accept && !w_illegal_size;
  assign w_apb_done     = (r_state == S_ACCESS) && PREADY;

  // State register; reset aborts any APB transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and per-state bus outputs.
  always_comb begin
    w_next_state = r_state;
    HREADY       = 1'b1;
    HRESP        = 1'b0;
    PSEL         = 1'b0;
    PENABLE      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (w_illegal_size) begin
            w_next_state = S_ERR1;
          end else if (HWRITE) begin
            w_next_state = S_WCAP;
          end else begin
            w_next_state = S_SETUP;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WCAP: begin
        HREADY       = 1'b0;
        w_next_state = S_SETUP;
      end
      S_SETUP: begin
        HREADY       = 1'b0;
        PSEL         = 1'b1;
        w_next_state = S_ACCESS;
      end
      S_ACCESS: begin
        HREADY  = 1'b0;
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          w_next_state = PSLVERR ? S_ERR1 : S_DONE;
        end
      end
      S_ERR1: begin
        HREADY       = 1'b0;
        HRESP        = 1'b1;
        w_next_state = S_ERR2;
      end
      S_ERR2: begin
        HRESP        = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Address-phase capture. Illegal-size beats never reach APB, so they leave
  // the APB-facing registers untouched. The registers then hold steady for
  // the whole SETUP/ACCESS window because the next accept can only happen in
  // IDLE or DONE.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pstrb  <= 4'b0000;
    end else if (w_legal_accept) begin
      r_paddr  <= HADDR[PADDR_W-1:0];
      r_pwrite <= HWRITE;
      r_pstrb  <= HWRITE ? f_write_strb(HSIZE, HADDR[1:0]) : 4'b0000;
    end
  end

  // Write data is valid in the AHB data phase, which is the WCAP cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pwdata <= '0;
    end else if (r_state == S_WCAP) begin
      r_pwdata <= HWDATA;
    end
  end

  // Read data is captured only on a successful APB read completion.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hrdata <= '0;
    end else if (w_apb_done && !PSLVERR && !r_pwrite) begin
      r_hrdata <= PRDATA;
    end
  end

  assign PADDR  = r_paddr;
  assign PWRITE = r_pwrite;
  assign PSTRB  = r_pstrb;
  assign PWDATA = r_pwdata;
  assign HRDATA = r_hrdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed testbench for ahb_apb_bridge.
// Inputs change 1 ns after the rising HCLK edge; outputs are checked at the
// same point, so each check sees the state entered at that edge.
module tb_ahb_apb_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_checks = 0;
  int n_errors = 0;

  ahb_apb_bridge #(.PADDR_W(16)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HTRANS   (HTRANS),
    .HADDR    (HADDR),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HWDATA   (HWDATA),
    .HREADYIN (HREADYIN),
    .HREADY   (HREADY),
    .HRESP    (HRESP),
    .HRDATA   (HRDATA),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL     = 1'b0;
    HTRANS   = 2'b00;
    HREADYIN = 1'b1;
  endtask

  task automatic drive_nonseq(input logic [31:0] addr, input logic wr,
                              input logic [1:0] size);
    HSEL     = 1'b1;
    HTRANS   = 2'b10;
    HADDR    = addr;
    HWRITE   = wr;
    HSIZE    = size;
    HBURST   = 3'b001;
    HREADYIN = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b1;
    bus_idle();
    HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 2'b10; HBURST = 3'b000;
    HWDATA = 32'h0; PRDATA = 32'h0; PREADY = 1'b1; PSLVERR = 1'b0;
    #1 HRESETn = 1'b0;
    #1;
    n_checks++; if (HREADY !== 1'b1) begin n_errors++; $display("FAIL reset_hready: got %b want 1", HREADY); end
    n_checks++; if (HRESP !== 1'b0) begin n_errors++; $display("FAIL reset_hresp: got %b want 0", HRESP); end
    n_checks++; if (HRDATA !== 32'h0) begin n_errors++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
    n_checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin n_errors++; $display("FAIL reset_pctrl: got %b want 000", {PSEL, PENABLE, PWRITE}); end
    n_checks++; if (PADDR !== 16'h0 || PWDATA !== 32'h0 || PSTRB !== 4'h0) begin n_errors++; $display("FAIL reset_pdata: got %h/%h/%b want 0/0/0", PADDR, PWDATA, PSTRB); end
    step();
    step();
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    n_checks++; if (HREADY !== 1'b1 || PSEL !== 1'b0) begin n_errors++; $display("FAIL reset_idle: got hready=%b psel=%b want 1/0", HREADY, PSEL); end
  endtask

  task automatic test_read();
    drive_nonseq(32'h0000_1234, 1'b0, 2'b10);
    PRDATA = 32'hDEAD_BEEF;
    PREADY = 1'b1;
    step(); // N+1
    bus_idle();
    n_checks++; if ({PSEL, PENABLE, HREADY} !== 3'b100) begin n_errors++; $display("FAIL rd_setup: got psel/pen/hrdy=%b want 100", {PSEL, PENABLE, HREADY}); end
    n_checks++; if (PADDR !== 16'h1234) begin n_errors++; $display("FAIL rd_paddr: got %h want 1234", PADDR); end
    n_checks++; if (PWRITE !== 1'b0 || PSTRB !== 4'b0000) begin n_errors++; $display("FAIL rd_pwrite_pstrb: got %b/%b want 0/0000", PWRITE, PSTRB); end
    step(); // N+2
    n_checks++; if ({PSEL, PENABLE, HREADY} !== 3'b110) begin n_errors++; $display("FAIL rd_access: got psel/pen/hrdy=%b want 110", {PSEL, PENABLE, HREADY}); end
    step(); // N+3
    n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin n_errors++; $display("FAIL rd_done: got hready=%b hresp=%b want 1/0", HREADY, HRESP); end
    n_checks++; if (HRDATA !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL rd_hrdata: got %h want deadbeef", HRDATA); end
    n_checks++; if (PSEL !== 1'b0) begin n_errors++; $display("FAIL rd_done_psel: got %b want 0", PSEL); end
    step(); // IDLE
    n_checks++; if (HREADY !== 1'b1 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin n_errors++; $display("FAIL rd_idle: got hrdy=%b psel=%b pen=%b want 1/0/0", HREADY, PSEL, PENABLE); end
  endtask

  task automatic test_write_wait();
    drive_nonseq(32'h0000_0003, 1'b1, 2'b00);
    HWDATA = 32'h1111_1111;
    PREADY = 1'b0;
    step(); // N+1 WCAP
    bus_idle();
    HWDATA = 32'hAABB_CCDD;
    n_checks++; if (HREADY !== 1'b0 || PSEL !== 1'b0) begin n_errors++; $display("FAIL wr_wcap: got hready=%b psel=%b want 0/0", HREADY, PSEL); end
    step(); // N+2 SETUP
    HWDATA = 32'h2222_2222;
    n_checks++; if ({PSEL, PENABLE} !== 2'b10) begin n_errors++; $display("FAIL wr_setup: got psel/pen=%b want 10", {PSEL, PENABLE}); end
    n_checks++; if (PWDATA !== 32'hAABB_CCDD) begin n_errors++; $display("FAIL wr_pwdata: got %h want aabbccdd", PWDATA); end
    n_checks++; if (PSTRB !== 4'b1000) begin n_errors++; $display("FAIL wr_pstrb: got %b want 1000", PSTRB); end
    n_checks++; if (PWRITE !== 1'b1 || PADDR !== 16'h0003) begin n_errors++; $display("FAIL wr_pwrite_paddr: got %b/%h want 1/0003", PWRITE, PADDR); end
    step(); // N+3 ACCESS, wait 1
    n_checks++; if ({PSEL, PENABLE, HREADY} !== 3'b110) begin n_errors++; $display("FAIL wr_wait1: got %b want 110", {PSEL, PENABLE, HREADY}); end
    step(); // N+4 ACCESS, wait 2
    n_checks++; if ({PSEL, PENABLE, HREADY} !== 3'b110) begin n_errors++; $display("FAIL wr_wait2: got %b want 110", {PSEL, PENABLE, HREADY}); end
    n_checks++; if (PWDATA !== 32'hAABB_CCDD || PSTRB !== 4'b1000 || PADDR !== 16'h0003 || PWRITE !== 1'b1) begin n_errors++; $display("FAIL wr_stable: got %h/%b/%h/%b want aabbccdd/1000/0003/1", PWDATA, PSTRB, PADDR, PWRITE); end
    step(); // N+5 ACCESS, completer ready
    PREADY = 1'b1;
    n_checks++; if (HREADY !== 1'b0 || PENABLE !== 1'b1) begin n_errors++; $display("FAIL wr_access_last: got hready=%b pen=%b want 0/1", HREADY, PENABLE); end
    step(); // N+6 DONE
    n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || PSEL !== 1'b0) begin n_errors++; $display("FAIL wr_done: got hrdy=%b hresp=%b psel=%b want 1/0/0", HREADY, HRESP, PSEL); end
    step(); // IDLE
  endtask

  task automatic test_slverr();
    drive_nonseq(32'h0000_0100, 1'b0, 2'b10);
    PRDATA  = 32'h1234_5678;
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    step(); // N+1 SETUP
    bus_idle();
    step(); // N+2 ACCESS
    n_checks++; if (PENABLE !== 1'b1) begin n_errors++; $display("FAIL err_access: got pen=%b want 1", PENABLE); end
    step(); // N+3 ERR1; offer a beat that must be dropped
    PSLVERR = 1'b0;
    drive_nonseq(32'h0000_0200, 1'b0, 2'b10);
    n_checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1 || PSEL !== 1'b0) begin n_errors++; $display("FAIL err_err1: got hrdy=%b hresp=%b psel=%b want 0/1/0", HREADY, HRESP, PSEL); end
    step(); // N+4 ERR2; still offering the beat
    n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin n_errors++; $display("FAIL err_err2: got hrdy=%b hresp=%b want 1/1", HREADY, HRESP); end
    n_checks++; if (HRDATA !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL err_hrdata_kept: got %h want deadbeef", HRDATA); end
    step(); // N+5 IDLE
    bus_idle();
    n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || PSEL !== 1'b0) begin n_errors++; $display("FAIL err_idle: got hrdy=%b hresp=%b psel=%b want 1/0/0", HREADY, HRESP, PSEL); end
    step();
    n_checks++; if (PSEL !== 1'b0 || HREADY !== 1'b1) begin n_errors++; $display("FAIL err_beat_dropped: got psel=%b hrdy=%b want 0/1", PSEL, HREADY); end
  endtask

  task automatic test_illegal_size();
    drive_nonseq(32'h0000_0300, 1'b1, 2'b11);
    step(); // N+1 ERR1
    bus_idle();
    n_checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1 || PSEL !== 1'b0) begin n_errors++; $display("FAIL ill_err1: got hrdy=%b hresp=%b psel=%b want 0/1/0", HREADY, HRESP, PSEL); end
    step(); // N+2 ERR2
    n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1 || PSEL !== 1'b0) begin n_errors++; $display("FAIL ill_err2: got hrdy=%b hresp=%b psel=%b want 1/1/0", HREADY, HRESP, PSEL); end
    step(); // N+3 IDLE
    n_checks++; if (HRESP !== 1'b0 || PSEL !== 1'b0 || HREADY !== 1'b1) begin n_errors++; $display("FAIL ill_idle: got hresp=%b psel=%b hrdy=%b want 0/0/1", HRESP, PSEL, HREADY); end
  endtask

  task automatic test_back_to_back();
    drive_nonseq(32'h0000_0010, 1'b0, 2'b10);
    PRDATA = 32'hCAFE_F00D;
    PREADY = 1'b1;
    step(); // N+1 SETUP
    bus_idle();
    step(); // N+2 ACCESS
    step(); // N+3 DONE; present the write here
    n_checks++; if (HREADY !== 1'b1 || HRDATA !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL b2b_rd_done: got hrdy=%b hrdata=%h want 1/cafef00d", HREADY, HRDATA); end
    drive_nonseq(32'h0000_0022, 1'b1, 2'b01);
    step(); // N+4 WCAP
    bus_idle();
    HWDATA = 32'h5566_7788;
    n_checks++; if (HREADY !== 1'b0 || HRESP !== 1'b0 || PSEL !== 1'b0) begin n_errors++; $display("FAIL b2b_wcap: got hrdy=%b hresp=%b psel=%b want 0/0/0", HREADY, HRESP, PSEL); end
    step(); // N+5 SETUP
    n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b1) begin n_errors++; $display("FAIL b2b_setup: got psel=%b pen=%b pwrite=%b want 1/0/1", PSEL, PENABLE, PWRITE); end
    n_checks++; if (PADDR !== 16'h0022 || PSTRB !== 4'b1100 || PWDATA !== 32'h5566_7788) begin n_errors++; $display("FAIL b2b_wdata: got %h/%b/%h want 0022/1100/55667788", PADDR, PSTRB, PWDATA); end
    step(); // N+6 ACCESS
    n_checks++; if (HREADY !== 1'b0 || PENABLE !== 1'b1) begin n_errors++; $display("FAIL b2b_access: got hrdy=%b pen=%b want 0/1", HREADY, PENABLE); end
    step(); // N+7 DONE
    n_checks++; if (HREADY !== 1'b1 || PSEL !== 1'b0) begin n_errors++; $display("FAIL b2b_wr_done: got hrdy=%b psel=%b want 1/0", HREADY, PSEL); end
    n_checks++; if (HRDATA !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL b2b_hrdata_kept: got %h want cafef00d", HRDATA); end
    step();
  endtask

  task automatic test_reset_mid_access();
    drive_nonseq(32'h0000_0040, 1'b0, 2'b10);
    PREADY = 1'b0;
    step(); // SETUP
    bus_idle();
    step(); // ACCESS, stalled
    n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin n_errors++; $display("FAIL rst_pre_access: got psel=%b pen=%b want 1/1", PSEL, PENABLE); end
    #2 HRESETn = 1'b0;
    #1;
    n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || HREADY !== 1'b1) begin n_errors++; $display("FAIL rst_async: got psel=%b pen=%b hrdy=%b want 0/0/1", PSEL, PENABLE, HREADY); end
    n_checks++; if (HRESP !== 1'b0 || HRDATA !== 32'h0 || PADDR !== 16'h0) begin n_errors++; $display("FAIL rst_async_regs: got hresp=%b hrdata=%h paddr=%h want 0/0/0", HRESP, HRDATA, PADDR); end
    step();
    drive_nonseq(32'h0000_0080, 1'b0, 2'b10);
    PRDATA = 32'h0BAD_CAFE;
    PREADY = 1'b1;
    @(negedge HCLK);
    HRESETn = 1'b1;
    step(); // accepted on first edge after release -> SETUP
    bus_idle();
    n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 16'h0080) begin n_errors++; $display("FAIL rst_first_accept: got psel=%b pen=%b paddr=%h want 1/0/0080", PSEL, PENABLE, PADDR); end
    step(); // ACCESS
    step(); // DONE
    n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0BAD_CAFE) begin n_errors++; $display("FAIL rst_next_xfer: got hrdy=%b hresp=%b hrdata=%h want 1/0/0badcafe", HREADY, HRESP, HRDATA); end
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_slverr();
    test_illegal_size();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
